// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath blocks: controller state
// encoding and width helpers for the multiply-accumulate unit.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned default_bits = 8;

  // Step counter must hold 0..bits.
  function automatic int cnt_width(input int bits);
    return $clog2(bits + 1);
  endfunction

  // q*b + r < 2^(2*bits+1), so this accumulator never wraps.
  function automatic int acc_width(input int bits);
    return 2 * bits + 1;
  endfunction

endpackage

// File: rtl/cntr.sv
// Up-counter with synchronous reset, synchronous clear and count enable.
module cntr #(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [width-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear) count <= '0;
    else if (en)        count <= count + width'(1);
  end

endmodule

// File: rtl/d_flip_flop.sv
// Enabled register with synchronous active-high clear.
module d_flip_flop #(
  parameter int width = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its inputs, regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/mul_fsm.sv
// IDLE/RUN/DONE controller for mul_add_n: captures on start, steps until the
// counter reports the last step, then raises ready for one cycle.
module mul_fsm
  import calc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic last,
  output logic first_cycle,
  output logic step,
  output logic ready
);

  state_t state, next;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next        = state;
    first_cycle = 1'b0;
    step        = 1'b0;
    ready       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          first_cycle = 1'b1;
          next        = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) next = DONE;
      end
      DONE: begin
        ready = 1'b1;
        next  = IDLE;
      end
      default: next = IDLE;
    endcase
  end

endmodule

// File: rtl/mul_add_n.sv
// Sequential shift-and-add unit computing res = q*b + r, the inverse of the
// repeated-subtraction divider, with overflow and illegal-remainder flags.
module mul_add_n
  import calc_pkg::*;
#(
  parameter int bits = default_bits
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [bits-1:0] q,
  input  logic [bits-1:0] b,
  input  logic [bits-1:0] r,
  output logic [bits-1:0] res,
  output logic            ovf,
  output logic            rem_err,
  output logic            rdy
);

  localparam int aw = acc_width(bits);
  localparam int cw = cnt_width(bits);

  logic            first_cycle, step, ready, last;
  logic [cw-1:0]   count;
  logic [bits-1:0] qreg, borig, rreg;
  logic [2*bits-1:0] breg;
  logic [aw-1:0]   acc, sum;
  logic            ovf_d, rem_err_d;

  mul_fsm u_fsm (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .last        (last),
    .first_cycle (first_cycle),
    .step        (step),
    .ready       (ready)
  );

  cntr #(.width(cw)) u_cntr (
    .clk   (clk),
    .reset (reset),
    .clear (first_cycle),
    .en    (step),
    .count (count)
  );

  assign last = (count == cw'(bits - 1));
  assign sum  = acc + aw'(breg);

  // Operands are latched on the capture edge, so later input changes
  // cannot disturb a running operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      qreg  <= '0;
      breg  <= '0;
      borig <= '0;
      rreg  <= '0;
      acc   <= '0;
    end else if (first_cycle) begin
      qreg  <= q;
      breg  <= (2 * bits)'(b);
      borig <= b;
      rreg  <= r;
      acc   <= aw'(r);
    end else if (step) begin
      if (qreg[0]) acc <= sum;
      breg <= breg << 1;
      qreg <= qreg >> 1;
    end
  end

  assign ovf_d     = |acc[aw-1:bits];
  assign rem_err_d = (rreg >= borig);

  d_flip_flop #(.width(bits)) u_res_ff (
    .clk(clk), .reset(reset), .en(ready), .d(acc[bits-1:0]), .q(res)
  );

  d_flip_flop #(.width(1)) u_ovf_ff (
    .clk(clk), .reset(reset), .en(ready), .d(ovf_d), .q(ovf)
  );

  d_flip_flop #(.width(1)) u_rem_err_ff (
    .clk(clk), .reset(reset), .en(ready), .d(rem_err_d), .q(rem_err)
  );

  // Delaying ready by one flop aligns rdy with the freshly loaded outputs.
  d_flip_flop #(.width(1)) u_rdy_ff (
    .clk(clk), .reset(reset), .en(1'b1), .d(ready), .q(rdy)
  );

endmodule
